// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types for the SRAM responder: request/response structs,
// access size encoding, responder state names and the alignment helper.
package dbus_sram_responder_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_WAIT = 2'd1,
        RSP_RESP = 2'd2
    } dbus_rsp_state_t;

    // Low address bits that must be zero for an access of the given size.
    function automatic logic [2:0] msize_align_mask(msize_t s);
        case (s)
            MSIZE1:  return 3'b000;
            MSIZE2:  return 3'b001;
            MSIZE4:  return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response bundle between an initiator and the responder.
interface dbus_sram_responder_if;
    import dbus_sram_responder_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_sram_responder_array.sv
// DEPTH x 64-bit storage: combinational read, byte-enabled posedge write.
// Contents are deliberately not reset.
module dbus_sram_responder_array #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned IDXW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [7:0]      be,
    input  logic [IDXW-1:0] idx,
    input  logic [63:0]     wdata,
    output logic [63:0]     rdata
);
    logic [63:0] mem [DEPTH];

    assign rdata = mem[idx];

    // Byte-lane write: only lanes with their enable set are updated.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end
endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus SRAM responder: captures a request, waits LATENCY cycles, then
// returns a one-cycle response. Out-of-range or misaligned requests still
// get a response but with fault set, zero data and no write.
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 4096,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    dbus_sram_responder_if.slave  dbus,
    output logic                  fault,
    output logic                  busy
);
    localparam int unsigned IDXW     = $clog2(DEPTH);
    localparam logic [63:0] SPAN     = 64'(DEPTH) * 64'd8;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'(RSP_IDLE);
    localparam logic [1:0] S_WAIT = 2'(RSP_WAIT);
    localparam logic [1:0] S_RESP = 2'(RSP_RESP);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [63:0] cap_addr;
    msize_t      cap_size;
    logic [7:0]  cap_strobe;
    logic [63:0] cap_data;

    logic [63:0]     off;
    logic            in_range;
    logic            aligned;
    logic            bad;
    logic [IDXW-1:0] idx;
    logic [63:0]     rd_word;
    logic            we;

    // Checks are made on the captured copy so late request changes are ignored.
    assign off      = cap_addr - BASE;
    assign in_range = off < SPAN;
    assign aligned  = (cap_addr[2:0] & msize_align_mask(cap_size)) == 3'b000;
    assign bad      = !(in_range && aligned);
    assign idx      = off[IDXW+2:3];
    assign we       = (state == S_RESP) && !bad && (cap_strobe != 8'h00);
    assign busy     = (state != S_IDLE);

    // Request FSM: accept in IDLE, count down in WAIT (abort on valid drop),
    // respond for one cycle in RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            cap_addr   <= '0;
            cap_size   <= MSIZE1;
            cap_strobe <= '0;
            cap_data   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dbus.dreq.valid) begin
                        cap_addr   <= dbus.dreq.addr;
                        cap_size   <= dbus.dreq.size;
                        cap_strobe <= dbus.dreq.strobe;
                        cap_data   <= dbus.dreq.data;
                        cnt        <= CNT_INIT;
                        state      <= (LATENCY == 1) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!dbus.dreq.valid) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) state <= S_RESP;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Response is only visible in RESP; faulted requests return zero data.
    always_comb begin
        dbus.dresp = '0;
        fault      = 1'b0;
        if (state == S_RESP) begin
            dbus.dresp.addr_ok = 1'b1;
            dbus.dresp.data_ok = 1'b1;
            dbus.dresp.data    = bad ? 64'd0 : rd_word;
            fault              = bad;
        end
    end

    dbus_sram_responder_array #(
        .DEPTH (DEPTH),
        .IDXW  (IDXW)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .be    (cap_strobe),
        .idx   (idx),
        .wdata (cap_data),
        .rdata (rd_word)
    );
endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: two instances (LATENCY 2 and 1) checked every
// cycle against a transaction-level model, plus literal expectations.
module tb_dbus_sram_responder;
    import dbus_sram_responder_pkg::*;

    localparam int unsigned DEPTH = 4096;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    longint cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dbus_req_t  req [2];
    dbus_resp_t rsp [2];
    logic       flt [2];
    logic       bsy [2];

    dbus_sram_responder_if if0();
    dbus_sram_responder_if if1();
    assign if0.dreq = req[0];
    assign if1.dreq = req[1];
    assign rsp[0]   = if0.dresp;
    assign rsp[1]   = if1.dresp;

    dbus_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(2)) u0 (
        .clk(clk), .reset(rst_n), .dbus(if0), .fault(flt[0]), .busy(bsy[0]));
    dbus_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) u1 (
        .clk(clk), .reset(rst_n), .dbus(if1), .fault(flt[1]), .busy(bsy[1]));

    // ---------------- model: one outstanding transaction per instance
    int          lat_of [2] = '{2, 1};
    bit          pend   [2];
    longint      due    [2];
    dbus_req_t   mreq   [2];
    logic [63:0] mm     [2][DEPTH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int k);
        logic        e_ok, e_flt, e_busy, bad;
        logic [63:0] e_d, off;
        e_ok = 0; e_flt = 0; e_busy = 0; e_d = 0;
        off = mreq[k].addr - BASE;
        bad = (off >= 64'(DEPTH) * 8) || ((mreq[k].addr % (64'd1 << mreq[k].size)) != 0);
        if (!rst_n) pend[k] = 0;
        else if (pend[k]) begin
            e_busy = 1;
            if (cyc == due[k]) begin
                e_ok  = 1;
                e_flt = bad;
                if (!bad) e_d = mm[k][int'(off >> 3)];
            end
        end
        chk($sformatf("u%0d.addr_ok", k), 64'(rsp[k].addr_ok), 64'(e_ok));
        chk($sformatf("u%0d.data_ok", k), 64'(rsp[k].data_ok), 64'(e_ok));
        chk($sformatf("u%0d.data", k),    rsp[k].data,         e_d);
        chk($sformatf("u%0d.fault", k),   64'(flt[k]),         64'(e_flt));
        chk($sformatf("u%0d.busy", k),    64'(bsy[k]),         64'(e_busy));
        if (rst_n) begin
            if (pend[k] && cyc == due[k]) begin
                if (!bad)
                    for (int i = 0; i < 8; i++)
                        if (mreq[k].strobe[i]) mm[k][int'(off >> 3)][i*8 +: 8] = mreq[k].data[i*8 +: 8];
                pend[k] = 0;
            end else if (pend[k] && !req[k].valid) begin
                pend[k] = 0;
            end else if (!pend[k] && req[k].valid) begin
                mreq[k] = req[k];
                pend[k] = 1;
                due[k]  = cyc + lat_of[k];
            end
        end
    endtask

    // ---------------- stimulus helpers (called at posedge + #1)
    task automatic issue(input int k, input logic [63:0] a, input msize_t sz,
                         input logic [7:0] st, input logic [63:0] d);
        req[k].valid  = 1'b1;
        req[k].addr   = a;
        req[k].size   = sz;
        req[k].strobe = st;
        req[k].data   = d;
    endtask

    task automatic wait_resp(input int k, output logic [63:0] d, output logic f, output longint rc);
        int n;
        n = 0; d = '0; f = 0; rc = -1;
        while (n < 40) begin
            @(negedge clk);
            if (rsp[k].data_ok === 1'b1) begin
                d = rsp[k].data; f = flt[k]; rc = cyc;
                break;
            end
            n++;
        end
        if (rc < 0) begin
            checks++; errors++;
            $display("FAIL u%0d.timeout no data_ok within 40 cycles", k);
        end
        @(posedge clk); #1;
    endtask

    task automatic xact(input int k, input logic [63:0] a, input msize_t sz,
                        input logic [7:0] st, input logic [63:0] d,
                        output logic [63:0] rd, output logic rf, output longint lat);
        longint t0, rc;
        t0 = cyc;
        issue(k, a, sz, st, d);
        wait_resp(k, rd, rf, rc);
        req[k].valid = 1'b0;
        lat = rc - t0;
    endtask

    // ---------------- main
    initial begin
        logic [63:0] d;
        logic        f;
        longint      lat, t0, rc;

        req[0] = '0; req[1] = '0;
        pend[0] = 0; pend[1] = 0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < int'(DEPTH); i++) mm[k][i] = '0;

        fork
            forever begin
                @(negedge clk);
                model_step(0);
                model_step(1);
            end
        join_none

        @(negedge clk);
        chk("reset.data_ok", 64'(rsp[0].data_ok), 64'd0);
        chk("reset.busy",    64'(bsy[0]),         64'd0);
        chk("reset.fault",   64'(flt[0]),         64'd0);
        chk("reset.data",    rsp[0].data,         64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // SD then LD, LATENCY=2
        xact(0, 64'h8000_0010, MSIZE8, 8'hFF, 64'h1122334455667788, d, f, lat);
        chk("sd.latency", 64'(lat), 64'd2);
        xact(0, 64'h8000_0010, MSIZE8, 8'h00, 64'h0, d, f, lat);
        chk("ld.data",  d, 64'h1122334455667788);
        chk("ld.fault", 64'(f), 64'd0);
        chk("ld.latency", 64'(lat), 64'd2);

        // SB lane 3
        xact(0, 64'h8000_0013, MSIZE1, 8'h08, 64'h0000_0000_AB00_0000, d, f, lat);
        xact(0, 64'h8000_0010, MSIZE8, 8'h00, 64'h0, d, f, lat);
        chk("sb.readback", d, 64'h11223344AB667788);

        // misaligned read and write
        xact(0, 64'h8000_0000, MSIZE8, 8'hFF, 64'h0123456789ABCDEF, d, f, lat);
        xact(0, 64'h8000_0002, MSIZE4, 8'h00, 64'h0, d, f, lat);
        chk("lw_mis.fault", 64'(f), 64'd1);
        chk("lw_mis.data",  d, 64'd0);
        xact(0, 64'h8000_0002, MSIZE4, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, d, f, lat);
        chk("sw_mis.fault", 64'(f), 64'd1);
        xact(0, 64'h8000_0000, MSIZE8, 8'h00, 64'h0, d, f, lat);
        chk("mis.readback", d, 64'h0123456789ABCDEF);

        // out of range, below base and at end
        xact(0, 64'h7FFF_FFF8, MSIZE8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, d, f, lat);
        chk("oor_lo.fault", 64'(f), 64'd1);
        chk("oor_lo.data",  d, 64'd0);
        chk("oor_lo.busy_after", 64'(bsy[0]), 64'd0);
        xact(0, BASE + 64'h7FF8, MSIZE8, 8'h00, 64'h0, d, f, lat);
        chk("oor_lo.nowrite", d, 64'd0);
        xact(0, BASE + 64'h8000, MSIZE8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, d, f, lat);
        chk("oor_hi.fault", 64'(f), 64'd1);
        chk("oor_hi.busy_after", 64'(bsy[0]), 64'd0);
        xact(0, BASE, MSIZE8, 8'h00, 64'h0, d, f, lat);
        chk("oor_hi.nowrite", d, 64'h0123456789ABCDEF);

        // LATENCY=1 page-walk style: preload, then valid held high
        xact(1, BASE + 64'h20,   MSIZE8, 8'hFF, 64'hA1A1_0000_0000_0001, d, f, lat);
        chk("l1.latency", 64'(lat), 64'd1);
        xact(1, BASE + 64'h28,   MSIZE8, 8'hFF, 64'hA2A2_0000_0000_0002, d, f, lat);
        xact(1, BASE + 64'h1000, MSIZE8, 8'hFF, 64'hA3A3_0000_0000_0003, d, f, lat);
        t0 = cyc;
        issue(1, BASE + 64'h20, MSIZE8, 8'h00, 64'h0);
        wait_resp(1, d, f, rc);
        chk("walk0.cycle", 64'(rc - t0), 64'd1);
        chk("walk0.data",  d, 64'hA1A1_0000_0000_0001);
        issue(1, BASE + 64'h28, MSIZE8, 8'h00, 64'h0);
        wait_resp(1, d, f, rc);
        chk("walk1.cycle", 64'(rc - t0), 64'd3);
        chk("walk1.data",  d, 64'hA2A2_0000_0000_0002);
        issue(1, BASE + 64'h1000, MSIZE8, 8'h00, 64'h0);
        wait_resp(1, d, f, rc);
        chk("walk2.cycle", 64'(rc - t0), 64'd5);
        chk("walk2.data",  d, 64'hA3A3_0000_0000_0003);
        req[1].valid = 1'b0;

        // reset during WAIT of an SD
        issue(0, BASE + 64'h100, MSIZE8, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
        @(posedge clk); #1;
        rst_n = 1'b0;
        req[0].valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_wait.no_data_ok", 64'(rsp[0].data_ok), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xact(0, BASE + 64'h100, MSIZE8, 8'h00, 64'h0, d, f, lat);
        chk("rst_wait.readback", d, 64'd0);

        // valid dropped during WAIT of an SD
        issue(0, BASE + 64'h108, MSIZE8, 8'hFF, 64'hCAFE_CAFE_CAFE_CAFE);
        @(posedge clk); #1;
        req[0].valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort.no_data_ok", 64'(rsp[0].data_ok), 64'd0);
        end
        @(posedge clk); #1;
        xact(0, BASE + 64'h108, MSIZE8, 8'h00, 64'h0, d, f, lat);
        chk("abort.readback", d, 64'd0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dbus_sram_responder.md
# dbus_sram_responder

Memory-side responder for the core's data bus. It accepts `dbus_req_t` requests from the MEM stage, or from the page-table walker sharing that port, and serves them from an internal byte-writable 64-bit SRAM after a configurable latency. It returns `dbus_resp_t` with a one-cycle `data_ok` pulse. It replaces the external memory model in block-level benches and serves as on-chip scratch RAM in the FPGA build.

## Interface
Parameters:
- `DEPTH`, 4096: number of 64-bit words; power of two.
- `BASE`, 64'h8000_0000: byte address of word 0.
- `LATENCY`, 2: cycles from request acceptance to `data_ok`; legal range 1..15.

Ports:
- `clk` in 1: single clock; all state on posedge.
- `reset` in 1: asynchronous, active-low reset.
- `dreq` in `dbus_req_t`: `valid`, `addr`, `size`, `strobe`, `data` from the initiator.
- `dresp` out `dbus_resp_t`: `addr_ok`, `data_ok`, `data`.
- `fault` out 1: pulses with `data_ok` when the request was out of range or misaligned.
- `busy` out 1: high in WAIT and RESP.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - If `dreq.valid` is high, capture `addr`, `size`, `strobe` and `data` into registers.
  - Load the counter with LATENCY-1.
  - Go to WAIT, or go directly to RESP when LATENCY=1.
- WAIT:
  - Decrement the counter.
  - At 0, go to RESP.
  - If `dreq.valid` falls during WAIT, abort to IDLE with no write and no response.
- RESP:
  - Drive `addr_ok` = `data_ok` = 1 for exactly one cycle.
  - Drive `dresp.data` = the full 64-bit word at the captured index. No lane extraction or sign extension; the initiator does that.
  - Return to IDLE.
- Index = (addr − BASE) >> 3, truncated to log2(DEPTH) bits.
- Range check: addr − BASE < DEPTH*8 (unsigned). Otherwise the request is out of range.
- Alignment check by size:
  - MSIZE2 requires addr[0]=0.
  - MSIZE4 requires addr[1:0]=0.
  - MSIZE8 requires addr[2:0]=0.
  - MSIZE1 is always aligned.
- Write: `strobe` ≠ 0. The write commits at the posedge ending the RESP cycle. Each set strobe bit i writes byte i from the captured data. `size` only affects the alignment check.
- Read: `strobe` = 0. No array update.
- Fault (out of range or misaligned):
  - `data_ok` is still returned.
  - `data` = 0 and `fault` = 1 in the RESP cycle.
  - No array write.
- Array contents are not reset. Simulation initial value is 0.

## Timing
- Reset values: `addr_ok` = `data_ok` = 0, `data` = 0, `fault` = 0, `busy` = 0, state IDLE, counter 0.
- Reset asserted in any state: return to IDLE at once and drop any pending write.
- Latency: a request with `valid` high in IDLE at cycle t gets `data_ok` in cycle t+LATENCY.
- The initiator holds the request stable until `data_ok`. The responder uses only the captured copy, so request changes after acceptance are ignored, except for the `valid` drop abort.
- Back-to-back requests are supported:
  - The cycle after RESP is IDLE; if `valid` is high there, it is a new request. This supports page-walk sequences that keep `valid` high with new addresses.
  - Throughput: one response per LATENCY+1 cycles.
- A read issued the cycle after a write's RESP observes the written data.
- The response is never asserted in IDLE or WAIT. `addr_ok` always equals `data_ok`.

## Structure
- Reuse `dbus_req_t`, `dbus_resp_t` and `msize_t` from `common`.
- Add the state enum `dbus_rsp_state_t` and the `MSIZE`-to-alignment-mask function to `common`.
- One sub-module, `dbus_sram_array`:
  - DEPTH×64 storage.
  - Combinational read by index.
  - Posedge write with 8-bit byte enable.
  - No reset.
- FSM, counter, capture registers and checks live in the top module.

## Test plan
- Reset, LATENCY=2, SD at 0x8000_0010 with data 0x1122334455667788 and strobe FF: `data_ok` 2 cycles after acceptance. Then LD at the same address returns 0x1122334455667788 with `fault` = 0.
- SB at 0x8000_0013 with data 0xAB (lane 3, strobe 08), then LD at 0x8000_0010: returns 0x11223344AB667788.
- LW at 0x8000_0002 (misaligned): `data_ok` = 1, `fault` = 1, `data` = 0. A prior SD at 0x8000_0000 is unchanged on readback.
- Access at 0x7FFF_FFF8 and at BASE+DEPTH*8: `fault` = 1, no write, `busy` returns low after RESP.
- `valid` held high with three different addresses, LATENCY=1: three `data_ok` pulses at cycles t+1, t+3, t+5 with the correct words.
- `reset` low during WAIT of an SD: no `data_ok`, and a later LD of that address returns the old value. Also, `valid` dropped during WAIT gives the same result.
